// File: rtl/reg_share_arbiter_pkg.sv
// Shared constants and helpers for the round-robin register-share arbiter.
package reg_share_arbiter_pkg;

  localparam int DEF_NUM_REQ = 4;
  localparam int DEF_WIDTH   = 8;

  // Wrap-around increment: n-1 rolls back to 0.
  function automatic int next_ptr(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_rr_select.sv
// Combinational round-robin selector: first asserted request at or after ptr,
// wrapping modulo NUM_REQ.
module rr_select
  import reg_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   winner_o,
  output logic               any_o
);

  logic             found;
  int               idx;
  logic [IDX_W-1:0] idx_v;

  always_comb begin
    gnt_o    = '0;
    winner_o = '0;
    found    = 1'b0;
    idx      = 0;
    idx_v    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = int'(ptr_i) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      idx_v = IDX_W'(idx);
      if (!found && req_i[idx_v]) begin
        found         = 1'b1;
        winner_o      = idx_v;
        gnt_o[idx_v]  = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin write arbiter sharing one WIDTH-bit register among NUM_REQ requesters.
// Optional grant locking is enabled with `define REG_SHARE_ARBITER_LOCK_EN.
module reg_share_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int WIDTH   = DEF_WIDTH,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] lock,
  input  logic [WIDTH-1:0]   data [NUM_REQ],
  output logic [NUM_REQ-1:0] gnt,
  output logic [WIDTH-1:0]   out,
  output logic [IDX_W-1:0]   out_owner,
  output logic               out_valid
);

  logic [WIDTH-1:0]   out_q,   out_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic               valid_q, valid_d;
  logic [IDX_W-1:0]   ptr_q,   ptr_d;
  logic [IDX_W-1:0]   last_q,  last_d;

  logic [NUM_REQ-1:0] req_eff;
  logic [NUM_REQ-1:0] rr_gnt;
  logic [IDX_W-1:0]   rr_winner;
  logic               rr_any;
  logic               lock_hold;
  logic [IDX_W-1:0]   winner;
  logic               any_gnt;

  // Reset masks requests so no grant is ever shown while rst is high.
  assign req_eff = rst ? '0 : req;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_select (
    .req_i    (req_eff),
    .ptr_i    (ptr_q),
    .gnt_o    (rr_gnt),
    .winner_o (rr_winner),
    .any_o    (rr_any)
  );

`ifdef REG_SHARE_ARBITER_LOCK_EN
  logic written_q, written_d;

  // The previous winner keeps the grant while it holds both req and lock,
  // but only once a real write has happened (last is meaningless before that).
  assign lock_hold = written_q && req_eff[last_q] && lock[last_q];
  assign written_d = written_q | any_gnt;

  always_ff @(posedge clk) begin
    if (rst) written_q <= 1'b0;
    else     written_q <= written_d;
  end
`else
  logic lock_unused;

  assign lock_hold   = 1'b0;
  assign lock_unused = ^lock;
`endif

  always_comb begin
    winner  = rr_winner;
    any_gnt = rr_any;
    gnt     = rr_gnt;
    if (lock_hold) begin
      winner         = last_q;
      any_gnt        = 1'b1;
      gnt            = '0;
      gnt[last_q]    = 1'b1;
    end
  end

  always_comb begin
    out_d   = out_q;
    owner_d = owner_q;
    valid_d = 1'b0;
    ptr_d   = ptr_q;
    last_d  = last_q;
    if (any_gnt) begin
      out_d   = data[winner];
      owner_d = winner;
      valid_d = 1'b1;
      last_d  = winner;
      // A locked re-grant leaves the round-robin pointer where it was.
      if (!lock_hold) ptr_d = IDX_W'(next_ptr(int'(winner), NUM_REQ));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_q   <= '0;
      owner_q <= '0;
      valid_q <= 1'b0;
      ptr_q   <= '0;
      last_q  <= '0;
    end else begin
      out_q   <= out_d;
      owner_q <= owner_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
    end
  end

  assign out       = out_q;
  assign out_owner = owner_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_reg_share_arbiter.sv
// Directed bench for reg_share_arbiter with hand-computed expectations.
module tb_reg_share_arbiter;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [3:0] lock;
  logic [7:0] data [4];
  logic [3:0] gnt;
  logic [7:0] out;
  logic [1:0] out_owner;
  logic       out_valid;

  int n_checks;
  int n_pass;

  reg_share_arbiter #(.NUM_REQ(4), .WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .lock      (lock),
    .data      (data),
    .gnt       (gnt),
    .out       (out),
    .out_owner (out_owner),
    .out_valid (out_valid)
  );

  // Clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Advance one rising edge, then settle away from it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic [7:0] v,
                           input logic [1:0] own, input logic vld);
    check({tag, "_out"},   32'(out),       32'(v));
    check({tag, "_owner"}, 32'(out_owner), 32'(own));
    check({tag, "_valid"}, 32'(out_valid), 32'(vld));
  endtask

  logic [3:0] lock_gnt_exp [3];

  initial begin
    n_checks = 0;
    n_pass   = 0;
    rst      = 1'b1;
    req      = 4'b1111;
    lock     = 4'b0000;
    data[0]  = 8'h11;
    data[1]  = 8'h22;
    data[2]  = 8'h33;
    data[3]  = 8'h44;
`ifdef REG_SHARE_ARBITER_LOCK_EN
    lock_gnt_exp[0] = 4'b0001;
    lock_gnt_exp[1] = 4'b0001;
    lock_gnt_exp[2] = 4'b0001;
`else
    lock_gnt_exp[0] = 4'b0001;
    lock_gnt_exp[1] = 4'b0010;
    lock_gnt_exp[2] = 4'b0001;
`endif

    // Reset held 5 cycles with all requests asserted
    for (int i = 0; i < 5; i++) begin
      step();
      check("rst_gnt", 32'(gnt), 32'h0);
      check_out("rst", 8'h00, 2'd0, 1'b0);
    end

    // Release: rotation 0,1,2,3,0
    rst = 1'b0;
    #1;
    check("rot_gnt0", 32'(gnt), 32'b0001);
    step();
    check_out("rot0", 8'h11, 2'd0, 1'b1);
    check("rot_gnt1", 32'(gnt), 32'b0010);
    step();
    check_out("rot1", 8'h22, 2'd1, 1'b1);
    check("rot_gnt2", 32'(gnt), 32'b0100);
    step();
    check_out("rot2", 8'h33, 2'd2, 1'b1);
    check("rot_gnt3", 32'(gnt), 32'b1000);
    step();
    check_out("rot3", 8'h44, 2'd3, 1'b1);
    check("rot_gnt4", 32'(gnt), 32'b0001);
    step();
    check_out("rot4", 8'h11, 2'd0, 1'b1);

    // Skip and wrap from ptr=1
    req = 4'b1001;
    #1;
    check("wrap_gnt0", 32'(gnt), 32'b1000);
    step();
    check_out("wrap0", 8'h44, 2'd3, 1'b1);
    check("wrap_gnt1", 32'(gnt), 32'b0001);
    step();
    check_out("wrap1", 8'h11, 2'd0, 1'b1);

    // Single requester, then idle hold
    req     = 4'b0100;
    data[2] = 8'hA5;
    #1;
    check("single_gnt", 32'(gnt), 32'b0100);
    step();
    check_out("single", 8'hA5, 2'd2, 1'b1);
    req = 4'b0000;
    #1;
    check("idle_gnt", 32'(gnt), 32'h0);
    step();
    check_out("idle", 8'hA5, 2'd2, 1'b0);

    // Lock on requester 0 for three cycles (ptr=3, last=2 here)
    req  = 4'b0011;
    lock = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("lock_gnt%0d", i), 32'(gnt), 32'(lock_gnt_exp[i]));
      step();
    end
    lock = 4'b0000;
    #1;
    check("unlock_gnt", 32'(gnt), 32'b0010);
    step();
    check_out("unlock", 8'h22, 2'd1, 1'b1);

    // Reset mid-operation at ptr=2
    req = 4'b1111;
    #1;
    check("mid_gnt_pre", 32'(gnt), 32'b0100);
    rst = 1'b1;
    #1;
    check("mid_gnt_rst", 32'(gnt), 32'h0);
    step();
    check_out("mid_rst", 8'h00, 2'd0, 1'b0);
    rst = 1'b0;
    #1;
    check("mid_gnt_rel", 32'(gnt), 32'b0001);
    step();
    check_out("mid_rel", 8'h11, 2'd0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/reg_share_arbiter.md
# reg_share_arbiter

Round-robin write arbiter that shares one WIDTH-bit storage register between NUM_REQ requesters. Each cycle it grants at most one requester, loads that requester's data into the shared register on the next rising edge, and reports which requester wrote last. It sits in front of the team's enable-gated register datapath and drives its load enable and data.

## Interface
- NUM_REQ, 4, number of requesters (>= 2)
- WIDTH, 8, data width of the shared register
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NUM_REQ  per-requester write request
- lock  in  NUM_REQ  per-requester hold-grant request (used only with lock feature)
- data  in  NUM_REQ x WIDTH (unpacked array)  per-requester write data
- gnt  out  NUM_REQ  one-hot grant, combinational
- out  out  WIDTH  shared register contents
- out_owner  out  $clog2(NUM_REQ)  index of last writer
- out_valid  out  1  high for exactly one cycle after each write

## Operation
- Internal state: ptr (highest-priority index), last (index of previous winner), register out, out_owner, out_valid.
- Arbitration: winner = first i with req[i]=1 searching ptr, ptr+1, ..., wrapping mod NUM_REQ. gnt = one-hot(winner); gnt = 0 if no req or rst=1.
- On rising edge with any gnt bit set: out <= data[winner]; out_owner <= winner; out_valid <= 1; last <= winner; ptr <= (winner+1) mod NUM_REQ (wrap NUM_REQ-1 -> 0).
- On rising edge with no grant: out, out_owner, ptr, last hold; out_valid <= 0.
- rst=1 at a rising edge: out=0, out_owner=0, out_valid=0, ptr=0, last=0; overrides any request in that cycle, including mid-sequence.
- Requester not granted keeps req asserted; no request queuing inside the block.

## Timing
- gnt: 0-cycle, combinational from req, lock, ptr, last.
- Write latency: data sampled at the edge ending the grant cycle; out/out_owner/out_valid visible in the following cycle.
- Continuous requests: one write per cycle, full throughput.
- First arbitration after reset release starts at index 0.
- Starvation bound without lock: any held request is granted within NUM_REQ cycles.

## Configuration
- Macro REG_SHARE_ARBITER_LOCK_EN.
- Defined: if req[last]=1 and lock[last]=1 and at least one write has occurred since reset, winner = last regardless of ptr; ptr does not advance. Lock released when lock[last] or req[last] drops; arbitration resumes from ptr.
- Undefined: lock port present but ignored; pure round-robin.

## Structure
- Package reg_share_arbiter_pkg: default NUM_REQ/WIDTH constants, function next_ptr(idx, n) for wrap-around increment.
- Sub-module rr_select: combinational round-robin select (req, ptr -> one-hot gnt, winner index, any_gnt). Top holds registers and lock override.

## Test plan
- Reset: rst=1 for 5 cycles with req=4'b1111 -> gnt=0, out=0, out_owner=0, out_valid=0 throughout; first grant after release = 4'b0001.
- Single requester: req=4'b0100, data[2]=8'hA5 -> gnt=4'b0100 same cycle; next cycle out=8'hA5, out_owner=2, out_valid=1; req dropped -> out_valid=0, out holds 8'hA5.
- Rotation: req=4'b1111 held from reset -> gnt sequence 0001, 0010, 0100, 1000, 0001; out tracks data[0..3] one cycle later.
- Skip and wrap: after grant to 0 (ptr=1), req=4'b1001 -> gnt=4'b1000, then 4'b0001.
- Lock (macro defined): req=4'b0011, lock=4'b0001 for 3 cycles -> gnt=4'b0001 three cycles, then 4'b0010 after lock drops; macro undefined -> gnt alternates 0001, 0010.
- Reset mid-operation: rst=1 for one cycle while req=4'b1111 and ptr=2 -> next cycle out=0, out_valid=0; first grant after release 4'b0001.
